// File: rtl/polyphase_coeff_bank_pkg.sv
// Shared definitions for the polyphase coefficient bank: FSM state encoding
// and default geometry matching the register map's coefficient memory.
package polyphase_coeff_bank_pkg;

  localparam int DEFAULT_DEPTH        = 512;
  localparam int DEFAULT_ADDR_WIDTH   = 9;
  localparam int DEFAULT_DATA_WIDTH   = 32;
  localparam int DEFAULT_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COPY    = 2'd2
  } state_t;

endpackage

// File: rtl/polyphase_coeff_bank_ram.sv
// coeff_bank_ram: true dual-port, byte-enabled RAM with 1-cycle registered reads.
// Port A reads every cycle (read-before-write) and writes enabled byte lanes;
// port B is read-only and holds its output when not enabled.
module coeff_bank_ram #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic [DATA_WIDTH/8-1:0] a_wen,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic                    b_en,
  output logic [DATA_WIDTH-1:0]   b_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Port A byte-lane writes; contents are never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (a_wen[i]) begin
        mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      end
    end
  end

  // Port A registered read, old data on a same-address write
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
    end else begin
      a_rdata <= mem[a_addr];
    end
  end

  // Port B registered read, holds value when not strobed
  always_ff @(posedge clk) begin
    if (rst) begin
      b_rdata <= '0;
    end else if (b_en) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/polyphase_coeff_bank.sv
// polyphase_coeff_bank: double-buffered coefficient store for the polyphase
// interpolation filter. Register side writes the shadow bank; a commit swaps
// banks only at a frame boundary. Optional feature macro
// POLYPHASE_COEFF_BANK_COPY_EN copies the new active bank into the new shadow
// after every swap so the shadow mirrors live coefficients.
module polyphase_coeff_bank
  import polyphase_coeff_bank_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   reg_addr,
  input  logic [DATA_WIDTH-1:0]   reg_wdata,
  input  logic [DATA_WIDTH/8-1:0] reg_wen,
  output logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    commit,
  input  logic                    frame_boundary,
  input  logic [ADDR_WIDTH-1:0]   filt_addr,
  input  logic                    filt_rd_en,
  output logic [DATA_WIDTH-1:0]   filt_coeff,
  output logic                    active_bank,
  output logic                    swap_pending,
  output logic                    busy,
  output logic                    write_dropped,
  output logic [7:0]              swap_count
);

  localparam int NB = DATA_WIDTH / 8;

  state_t state, state_next;
  logic   swap, commit_accept, wr_ok, wr_drop;
  logic   reg_sel, filt_sel;

  logic                  copy_active, copy_wr;
  logic [ADDR_WIDTH-1:0] copy_raddr, copy_waddr;
  logic [DATA_WIDTH-1:0] copy_data;

  logic [ADDR_WIDTH-1:0] a_addr  [2];
  logic [DATA_WIDTH-1:0] a_wdata [2];
  logic [NB-1:0]         a_wen   [2];
  logic [DATA_WIDTH-1:0] a_rdata [2];
  logic                  b_en    [2];
  logic [DATA_WIDTH-1:0] b_rdata [2];

`ifdef POLYPHASE_COEFF_BANK_COPY_EN
  localparam state_t AFTER_SWAP = ST_COPY;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0] copy_cnt;
  logic                copy_last;
  logic                commit_latched, commit_latched_next;

  assign copy_active = (state == ST_COPY);
  assign copy_last   = copy_active && (copy_cnt == CNT_LAST);
  assign copy_wr     = copy_active && (copy_cnt != '0);
  assign copy_raddr  = copy_cnt[ADDR_WIDTH-1:0];
  assign copy_waddr  = copy_cnt[ADDR_WIDTH-1:0] - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Copy index: counts 0..DEPTH while in COPY, read at k and write k-1
  always_ff @(posedge clk) begin
    if (rst) begin
      copy_cnt <= '0;
    end else if (copy_active) begin
      copy_cnt <= copy_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      copy_cnt <= '0;
    end
  end

  // Remember a commit arriving during COPY so PENDING follows the copy
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_latched <= 1'b0;
    end else begin
      commit_latched <= commit_latched_next;
    end
  end
`else
  localparam state_t AFTER_SWAP = ST_IDLE;

  assign copy_active = 1'b0;
  assign copy_wr     = 1'b0;
  assign copy_raddr  = '0;
  assign copy_waddr  = '0;
`endif

  assign copy_data = a_rdata[active_bank];
  assign wr_drop   = (reg_wen != '0) && !wr_ok;

  // Next-state logic: commit handling, swap decision and write acceptance
  always_comb begin
    state_next    = state;
    swap          = 1'b0;
    commit_accept = 1'b0;
    wr_ok         = 1'b0;
`ifdef POLYPHASE_COEFF_BANK_COPY_EN
    commit_latched_next = commit_latched;
`endif
    case (state)
      ST_IDLE: begin
        wr_ok = 1'b1;
        if (commit) begin
          commit_accept = 1'b1;
          if (frame_boundary) begin
            swap       = 1'b1;
            state_next = AFTER_SWAP;
          end else begin
            state_next = ST_PENDING;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (frame_boundary) begin
          swap       = 1'b1;
          state_next = AFTER_SWAP;
        end else begin
          state_next = ST_PENDING;
        end
      end
`ifdef POLYPHASE_COEFF_BANK_COPY_EN
      ST_COPY: begin
        if (commit) begin
          commit_accept       = 1'b1;
          commit_latched_next = 1'b1;
        end else begin
          commit_latched_next = commit_latched;
        end
        if (copy_last) begin
          state_next          = (commit_latched || commit) ? ST_PENDING : ST_IDLE;
          commit_latched_next = 1'b0;
        end else begin
          state_next = ST_COPY;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, bank index and swap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      active_bank <= 1'b0;
      swap_count  <= 8'd0;
    end else begin
      state <= state_next;
      if (swap) begin
        active_bank <= ~active_bank;
        swap_count  <= swap_count + 8'd1;
      end
    end
  end

  // Sticky refused-write flag; a refused write wins over a clearing commit
  always_ff @(posedge clk) begin
    if (rst) begin
      write_dropped <= 1'b0;
    end else if (wr_drop) begin
      write_dropped <= 1'b1;
    end else if (commit_accept) begin
      write_dropped <= 1'b0;
    end
  end

  // Output bank selects track which bank each read was issued to
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_sel  <= 1'b1;
      filt_sel <= 1'b0;
    end else begin
      reg_sel <= ~active_bank;
      if (filt_rd_en) begin
        filt_sel <= active_bank;
      end
    end
  end

  // Port steering: active bank serves copy reads and filter reads,
  // shadow bank serves register access or copy writes
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      a_addr[i]  = reg_addr;
      a_wdata[i] = reg_wdata;
      a_wen[i]   = '0;
      b_en[i]    = filt_rd_en && (1'(i) == active_bank);
      if (1'(i) == active_bank) begin
        a_addr[i] = copy_active ? copy_raddr : reg_addr;
      end else if (copy_active) begin
        a_addr[i]  = copy_waddr;
        a_wdata[i] = copy_data;
        a_wen[i]   = copy_wr ? {NB{1'b1}} : {NB{1'b0}};
      end else begin
        a_wen[i] = wr_ok ? reg_wen : {NB{1'b0}};
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    coeff_bank_ram #(
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .a_addr (a_addr[g]),
      .a_wdata(a_wdata[g]),
      .a_wen  (a_wen[g]),
      .a_rdata(a_rdata[g]),
      .b_addr (filt_addr),
      .b_en   (b_en[g]),
      .b_rdata(b_rdata[g])
    );
  end

  assign reg_rdata    = a_rdata[reg_sel];
  assign filt_coeff   = b_rdata[filt_sel];
  assign swap_pending = (state == ST_PENDING);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_polyphase_coeff_bank.sv
// Directed self-checking bench for polyphase_coeff_bank (default geometry).
// Build with POLYPHASE_COEFF_BANK_COPY_EN defined to exercise the copy feature.
module tb_polyphase_coeff_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wen;
  logic [31:0] reg_rdata;
  logic        commit, frame_boundary;
  logic [8:0]  filt_addr;
  logic        filt_rd_en;
  logic [31:0] filt_coeff;
  logic        active_bank, swap_pending, busy, write_dropped;
  logic [7:0]  swap_count;

  int checks = 0;
  int errors = 0;

  polyphase_coeff_bank dut (
    .clk(clk), .rst(rst),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wen(reg_wen), .reg_rdata(reg_rdata),
    .commit(commit), .frame_boundary(frame_boundary),
    .filt_addr(filt_addr), .filt_rd_en(filt_rd_en), .filt_coeff(filt_coeff),
    .active_bank(active_bank), .swap_pending(swap_pending), .busy(busy),
    .write_dropped(write_dropped), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    reg_addr = a; reg_wdata = d; reg_wen = be;
    tick();
    reg_wen = 4'h0;
  endtask

  task automatic rd(input logic [8:0] a);
    reg_addr = a;
    tick();
  endtask

  task automatic frd(input logic [8:0] a);
    filt_addr = a; filt_rd_en = 1'b1;
    tick();
    filt_rd_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    rst = 1'b1; reg_addr = 9'd0; reg_wdata = 32'd0; reg_wen = 4'h0;
    commit = 1'b0; frame_boundary = 1'b0; filt_addr = 9'd0; filt_rd_en = 1'b0;
    tick(); tick();

    // reset state, sampled while reset is held
    chk("rst_active_bank", 32'(active_bank), 32'd0);
    chk("rst_swap_pending", 32'(swap_pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write_dropped", 32'(write_dropped), 32'd0);
    chk("rst_swap_count", 32'(swap_count), 32'd0);
    chk("rst_reg_rdata", reg_rdata, 32'd0);
    chk("rst_filt_coeff", filt_coeff, 32'd0);
    rst = 1'b0;

    // write then read back, full word and single lane
    wr(9'd5, 32'hDEADBEEF, 4'hF);
    rd(9'd5);
    chk("rdback_full", reg_rdata, 32'hDEADBEEF);
    wr(9'd5, 32'h000000AA, 4'h1);
    rd(9'd5);
    chk("rdback_lane0", reg_rdata, 32'hDEADBEAA);

    // load shadow (bank 1) with i+0x200, plus a marker at the last address
    for (int i = 0; i < 8; i++) wr(9'(i), 32'h200 + 32'(i), 4'hF);
    wr(9'd511, 32'h000002FF, 4'hF);

    // same-cycle commit and frame boundary swap immediately
    commit = 1'b1; frame_boundary = 1'b1;
    tick();
    commit = 1'b0; frame_boundary = 1'b0;
    chk("same_cyc_pending", 32'(swap_pending), 32'd0);
    chk("same_cyc_bank", 32'(active_bank), 32'd1);
    chk("same_cyc_count", 32'(swap_count), 32'd1);
`ifdef POLYPHASE_COEFF_BANK_COPY_EN
    wait_idle("copy1_busy_cycles", 513);
`endif
    frd(9'd3);
    chk("filt_bank1_a3", filt_coeff, 32'h203);
    filt_addr = 9'd4;
    tick();
    chk("filt_hold", filt_coeff, 32'h203);

    // deferred swap: load shadow (bank 0) with i+0x100 and commit
    for (int i = 0; i < 8; i++) wr(9'(i), 32'h100 + 32'(i), 4'hF);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("defer_pending", 32'(swap_pending), 32'd1);
    chk("defer_busy", 32'(busy), 32'd1);
    frd(9'd3);
    chk("defer_old_data", filt_coeff, 32'h203);

    // dropped write while pending leaves the shadow untouched
    wr(9'd2, 32'h00000BAD, 4'hF);
    chk("drop_flag", 32'(write_dropped), 32'd1);
    rd(9'd2);
    chk("drop_shadow", reg_rdata, 32'h102);

    // a second commit while pending is ignored and does not clear the flag
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("pend_commit_flag", 32'(write_dropped), 32'd1);
    chk("pend_commit_pending", 32'(swap_pending), 32'd1);

    // frame boundary with a filter read in the swap cycle itself
    frame_boundary = 1'b1; filt_addr = 9'd3; filt_rd_en = 1'b1;
    tick();
    frame_boundary = 1'b0; filt_rd_en = 1'b0;
    chk("swap_cyc_old", filt_coeff, 32'h203);
    chk("swap2_bank", 32'(active_bank), 32'd0);
    chk("swap2_count", 32'(swap_count), 32'd2);
    chk("swap2_pending", 32'(swap_pending), 32'd0);
`ifdef POLYPHASE_COEFF_BANK_COPY_EN
    wait_idle("copy2_busy_cycles", 513);
`endif
    frd(9'd3);
    chk("swap2_new_data", filt_coeff, 32'h103);
    rd(9'd3);
`ifdef POLYPHASE_COEFF_BANK_COPY_EN
    chk("shadow_mirror_a3", reg_rdata, 32'h103);
    rd(9'd511);
    chk("shadow_mirror_a511", reg_rdata, 32'h2FF);
    frd(9'd511);
    chk("filt_a511", filt_coeff, 32'h2FF);
`else
    chk("shadow_prev_set", reg_rdata, 32'h203);
`endif
    chk("flag_kept", 32'(write_dropped), 32'd1);

    // next accepted commit clears the sticky flag
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("commit_clears", 32'(write_dropped), 32'd0);
    chk("commit3_pending", 32'(swap_pending), 32'd1);

    // reset in the middle of PENDING
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bank", 32'(active_bank), 32'd0);
    chk("midrst_count", 32'(swap_count), 32'd0);
    chk("midrst_pending", 32'(swap_pending), 32'd0);
    wr(9'd6, 32'h12345678, 4'hF);
    chk("midrst_no_drop", 32'(write_dropped), 32'd0);
    rd(9'd6);
    chk("midrst_write", reg_rdata, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/polyphase_coeff_bank.md
# polyphase_coeff_bank

Double-buffered coefficient store for the DVB-S2 TX polyphase interpolation filter. It sits between the register file's `polyphase_filter_coefficients` memory port and the filter datapath. Software writes a complete coefficient set into a shadow bank while the filter keeps reading the active bank. A commit request swaps the banks only at a frame boundary, so no frame is ever filtered with a mixed coefficient set.

## Interface
Parameters:
- `DEPTH`, 512: coefficients per bank.
- `ADDR_WIDTH`, 9: equals clog2(`DEPTH`).
- `DATA_WIDTH`, 32: coefficient word width; a multiple of 8.

Ports:
- `clk`, in, 1: single clock for the block.
- `rst`, in, 1: synchronous, active-high reset.
- `reg_addr`, in, `ADDR_WIDTH`: register-side address into the shadow bank.
- `reg_wdata`, in, `DATA_WIDTH`: register-side write data.
- `reg_wen`, in, `DATA_WIDTH`/8: byte-lane write enables.
- `reg_rdata`, out, `DATA_WIDTH`: shadow-bank read data, 1-cycle latency.
- `commit`, in, 1: single-cycle pulse requesting a bank swap.
- `frame_boundary`, in, 1: single-cycle pulse from the filter marking the end of a frame at its input.
- `filt_addr`, in, `ADDR_WIDTH`: filter read address into the active bank.
- `filt_rd_en`, in, 1: filter read strobe.
- `filt_coeff`, out, `DATA_WIDTH`: active-bank data, 1-cycle latency.
- `active_bank`, out, 1: index of the bank the filter is reading.
- `swap_pending`, out, 1: a commit is waiting for a frame boundary.
- `busy`, out, 1: register writes are currently refused.
- `write_dropped`, out, 1: sticky flag, set when a write is refused.
- `swap_count`, out, 8: number of completed swaps, wraps 255→0.

## Operation
- The block holds two banks, 0 and 1. The filter reads bank `active_bank`; the register side writes and reads the other bank (the shadow).
- FSM states are IDLE, PENDING and COPY. COPY exists only when the Configuration macro is defined.
- **IDLE**
  - Any nonzero `reg_wen` writes the enabled byte lanes of `reg_wdata` into shadow[`reg_addr`].
  - `commit` moves the FSM to PENDING.
  - If `commit` and `frame_boundary` arrive in the same cycle, the swap happens in that cycle and PENDING is skipped.
- **PENDING**
  - `swap_pending`=1 and `busy`=1.
  - Writes are dropped and set `write_dropped`.
  - On `frame_boundary`: `active_bank` toggles, `swap_count` increments, and the FSM goes to COPY if compiled in, otherwise to IDLE.
  - A further `commit` while in PENDING is ignored.
- **COPY**
  - `busy`=1 and writes are dropped.
  - Index k runs 0..`DEPTH`-1, one word per cycle: the new active bank is read at k and the word is written into the new shadow bank at k one cycle later.
  - Exit to IDLE happens after the write of index `DEPTH`-1.
  - A `commit` during COPY is latched and the FSM enters PENDING on exit.
- `write_dropped` clears on the next accepted `commit`, or on `rst`.
- Reset values: `active_bank`=0, FSM=IDLE, `swap_pending`=0, `busy`=0, `write_dropped`=0, `swap_count`=0, `reg_rdata`=0, `filt_coeff`=0. Bank contents are not reset.
- A reset in the middle of a COPY aborts it. The shadow bank is then partially copied, and that is acceptable.

## Timing
- `reg_rdata` presents shadow[`reg_addr`] sampled in cycle N during cycle N+1.
- A write followed by a read of the same address in the next cycle returns the new data.
- `filt_coeff` updates during N+1 only when `filt_rd_en` is high in cycle N; otherwise it holds its value.
- The swap takes effect from the cycle after `frame_boundary`. A filter read issued in the swap cycle itself still returns old-bank data.
- After a swap, the register-side readback moves to the new shadow bank from the next cycle.
- COPY lasts `DEPTH`+1 cycles from entry to IDLE.
- `commit` to swap latency is the time until the next `frame_boundary`, with a minimum of 0 cycles (the same-cycle case).

## Configuration
- `POLYPHASE_COEFF_BANK_COPY_EN` defined: after every swap the new active bank is copied into the new shadow bank. The shadow then mirrors live coefficients, so software can patch single taps and commit.
- Macro undefined: no COPY state; `busy` equals `swap_pending`. After a swap the shadow holds the previous coefficient set, and software must rewrite all `DEPTH` words before committing.

## Structure
- The shared package holds:
  - the FSM state enum;
  - the default `DEPTH`/`DATA_WIDTH` constants, matching the regmap memory depth (512) and read latency (1).
- Sub-module `coeff_bank_ram`: a true dual-port, byte-enabled, 1-cycle-read RAM, instantiated twice.
  - Port A serves register writes/reads, plus copy reads (on the active bank) and copy writes (on the shadow bank).
  - Port B serves filter reads only.

## Test plan
- **Write then read back:** write 0xDEADBEEF to addr 5 with `reg_wen`=0xF, then read addr 5 → `reg_rdata`=0xDEADBEEF next cycle. Then write 0x000000AA with `reg_wen`=0x1 and read → 0xDEADBEAA.
- **Deferred swap:** load the shadow with i+0x100 at each addr i and pulse `commit`; the filter reads addr 3 → old data and `swap_pending`=1. Pulse `frame_boundary`; the next read of addr 3 → 0x103, `active_bank`=1, `swap_count`=1.
- **Same-cycle commit and boundary:** `commit` and `frame_boundary` in the same cycle → `swap_pending` never asserts and `active_bank` toggles in the next cycle.
- **Dropped write:** a write while PENDING → shadow is unchanged and `write_dropped`=1. The next `commit` clears it.
- **With `POLYPHASE_COEFF_BANK_COPY_EN`:** after a swap, `busy` stays high for 513 cycles; afterwards `reg_rdata` at addr 511 equals `filt_coeff` at addr 511.
- **Reset mid-operation:** assert `rst` during COPY or PENDING → next cycle `busy`=0, `active_bank`=0, `swap_count`=0, and a new write is accepted.
